// File: rtl/imem_arbiter_if.sv
// Loader, fetch and instruction-memory port bundle for imem_arbiter.
// slave = arbiter side, master = requester/memory side.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ld_req;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_wdata;
  logic                  ld_done;
  logic                  ld_ack;
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  err;
  logic                  core_stall;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, ld_done, if_req, if_addr, mem_rdata,
    output ld_ack, if_rdata, if_valid, err, core_stall, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, ld_done, if_req, if_addr, mem_rdata,
    input  ld_ack, if_rdata, if_valid, err, core_stall, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates boot-loader writes and instruction fetches onto one instruction memory port.
// Optional macro IMEM_ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE (default: loader wins).
module imem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_SIZE   = 1024
) (
  input logic           clk,
  input logic           reset_n,
  imem_arbiter_if.slave bus
);

  localparam int unsigned CMP_W = ADDR_WIDTH + 1;
  localparam logic [CMP_W-1:0] MEM_LIMIT = CMP_W'(MEM_SIZE);

  typedef enum logic [1:0] {BOOT, IDLE, WRITE, READ} state_t;

  state_t                r_state;
  logic                  r_src_boot;
  logic                  r_oor;
  logic                  r_ld_ack;
  logic                  r_if_valid;
  logic                  r_err;
  logic                  r_core_stall;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;

  logic                  w_ld_oor;
  logic                  w_if_oor;
  logic                  w_grant_ld;
  logic                  w_grant_if;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  // 0: loader wins the next tie, 1: fetch wins the next tie.
  logic                  r_rr_ptr;
`endif

  assign w_ld_oor = {1'b0, bus.ld_addr} >= MEM_LIMIT;
  assign w_if_oor = {1'b0, bus.if_addr} >= MEM_LIMIT;

  // Grant decode; grants only come from BOOT/IDLE, so a completing access never chains directly.
  always_comb begin
    w_grant_ld = 1'b0;
    w_grant_if = 1'b0;
    case (r_state)
      BOOT: w_grant_ld = bus.ld_req && !bus.ld_done;
      IDLE: begin
`ifdef IMEM_ARB_ROUND_ROBIN_EN
        if (bus.ld_req && bus.if_req) begin
          w_grant_ld = !r_rr_ptr;
          w_grant_if = r_rr_ptr;
        end else begin
          w_grant_ld = bus.ld_req;
          w_grant_if = bus.if_req;
        end
`else
        w_grant_ld = bus.ld_req;
        w_grant_if = bus.if_req && !bus.ld_req;
`endif
      end
      default: begin
        w_grant_ld = 1'b0;
        w_grant_if = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= BOOT;
      r_src_boot   <= 1'b1;
      r_oor        <= 1'b0;
      r_ld_ack     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_core_stall <= 1'b1;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
      r_rr_ptr     <= 1'b0;
`endif
    end else begin
      r_ld_ack   <= 1'b0;
      r_if_valid <= 1'b0;
      r_err      <= 1'b0;
      r_mem_wr   <= 1'b0;

      case (r_state)
        BOOT, IDLE: begin
          if (r_state == BOOT && bus.ld_done) begin
            r_state      <= IDLE;
            r_core_stall <= 1'b0;
          end else if (w_grant_ld) begin
            r_mem_addr  <= bus.ld_addr;
            r_mem_wdata <= bus.ld_wdata;
            r_mem_wr    <= !w_ld_oor;
            r_oor       <= w_ld_oor;
            r_src_boot  <= (r_state == BOOT);
            r_state     <= WRITE;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            r_rr_ptr    <= 1'b1;
`endif
          end else if (w_grant_if) begin
            r_mem_addr  <= bus.if_addr;
            r_oor       <= w_if_oor;
            r_src_boot  <= 1'b0;
            r_state     <= READ;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
            r_rr_ptr    <= 1'b0;
`endif
          end
        end

        WRITE: begin
          r_ld_ack <= 1'b1;
          r_err    <= r_oor;
          r_state  <= r_src_boot ? BOOT : IDLE;
        end

        READ: begin
          r_if_valid <= 1'b1;
          r_err      <= r_oor;
          r_if_rdata <= r_oor ? '0 : bus.mem_rdata;
          r_state    <= IDLE;
        end

        default: r_state <= BOOT;
      endcase
    end
  end

  assign bus.ld_ack     = r_ld_ack;
  assign bus.if_valid   = r_if_valid;
  assign bus.err        = r_err;
  assign bus.core_stall = r_core_stall;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.if_rdata   = r_if_rdata;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, word width; MEM_SIZE, default 1024, number of words in instruction memory.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 ld_req  in  1  loader write request; held high until ld_ack.
REQ-005 ld_addr  in  ADDR_WIDTH  loader word address; stable while ld_req is high.
REQ-006 ld_wdata  in  DATA_WIDTH  loader write data; stable while ld_req is high.
REQ-007 ld_done  in  1  loader finished; level-sensitive.
REQ-008 ld_ack  out  1  one-cycle pulse: write completed or rejected.
REQ-009 if_req  in  1  fetch read request; held high until if_valid.
REQ-010 if_addr  in  ADDR_WIDTH  fetch word address; stable while if_req is high.
REQ-011 if_rdata  out  DATA_WIDTH  registered fetch data; valid when if_valid is high.
REQ-012 if_valid  out  1  one-cycle pulse: fetch completed or rejected.
REQ-013 err  out  1  one-cycle pulse with ld_ack or if_valid when the address is not less than MEM_SIZE.
REQ-014 core_stall  out  1  high while in BOOT.
REQ-015 mem_wr, mem_addr, mem_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  registered drive to the instruction memory port.
REQ-016 mem_rdata  in  DATA_WIDTH  combinational read data from instruction memory.

Function
REQ-017 States SHALL be BOOT, IDLE, WRITE, READ.
REQ-018 BOOT: serve only ld_req and ignore if_req; on ld_done=1 with no access in flight, go to IDLE at the next edge.
REQ-019 IDLE: sample requests, grant one per edge, and register mem_addr, mem_wdata and mem_wr for the granted access.
REQ-020 WRITE: mem_wr=1 for exactly one cycle; at the next edge mem_wr=0, ld_ack pulses for 1 cycle, and the FSM returns to the source state (BOOT or IDLE).
REQ-021 READ: mem_wr=0; at the next edge capture mem_rdata into if_rdata, pulse if_valid for 1 cycle, and return to IDLE.
REQ-022 Latency: request sampled at edge N gives ld_ack or if_valid high during cycle N+1 to N+2; peak throughput is one access per 2 cycles.
REQ-023 A requester SHALL NOT be re-granted in the cycle its ack or valid is high, so a held request is not double-served.
REQ-024 Out-of-range address (addr >= MEM_SIZE): mem_wr is never asserted; ld_ack or if_valid pulses with err=1 on the same timeline; if_rdata=0.
REQ-025 mem_wr=0 in every state except WRITE; mem_addr holds its last value when idle.
REQ-026 Arbitration with both requests in IDLE follows REQ-033 and REQ-034.
REQ-027 ld_done rising mid-write: the write completes, then the FSM goes BOOT->IDLE at the edge after ld_ack.
REQ-028 In IDLE, ld_done returning low SHALL NOT re-enter BOOT.

Reset
REQ-029 reset_n low SHALL immediately force state to BOOT and set ld_ack=0, if_valid=0, err=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_rdata=0, core_stall=1, and the round-robin pointer to loader.
REQ-030 Reset asserted mid-WRITE or mid-READ SHALL abort the access with no ack/valid pulse; mem_wr drops asynchronously.
REQ-031 On reset_n deassertion, the first grant SHALL occur at the first edge with reset_n high.

Configuration
REQ-032 Macro IMEM_ARB_ROUND_ROBIN_EN selects the arbitration policy used when both requests are pending in IDLE.
REQ-033 Without IMEM_ARB_ROUND_ROBIN_EN: fixed priority, loader wins.
REQ-034 With IMEM_ARB_ROUND_ROBIN_EN: the 1-bit pointer alternates, the last-granted requester loses the next tie, and the pointer updates only on a grant.

Verification
REQ-035 Reset, then ld_req with addr=0, wdata=0x00100093 -> mem_wr high 1 cycle with mem_addr=0, then ld_ack pulse with err=0; core_stall=1.
REQ-036 if_req with addr=3 in BOOT -> no if_valid; assert ld_done -> core_stall=0 at the next edge, then if_valid with if_rdata equal to mem_rdata at addr 3.
REQ-037 In IDLE, if_req with addr=1024 -> if_valid and err pulse together, if_rdata=0, mem_wr never high.
REQ-038 ld_req and if_req held together for 8 cycles in IDLE -> without the macro: ld_ack only, 4 pulses; with the macro: ld_ack and if_valid alternate, 2 each.
REQ-039 reset_n pulled low in the WRITE cycle -> mem_wr=0 immediately, no ld_ack, state is BOOT after release.
